// File: rtl/core_pkg.sv
// Shared types for the core pipeline control: forwarding selects, result-source
// encodings and the memory-wait FSM state.
package core_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } memwait_state_t;

    // A destination register only matters when it is written and is not x0.
    function automatic logic reg_hit(input logic       i_we,
                                     input logic [4:0] i_rd,
                                     input logic [4:0] i_rs);
        return i_we && (i_rd == i_rs) && (i_rs != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select for the execute stage; M beats W, x0 never forwarded.
module hazard_fwd_sel
    import core_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_m,
    input  logic       i_reg_write_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_w,
    output fwd_sel_t   o_sel
);

    logic w_hit_m;
    logic w_hit_w;

    assign w_hit_m = reg_hit(i_reg_write_m, i_rd_m, i_rs);
    assign w_hit_w = reg_hit(i_reg_write_w, i_rd_w, i_rs);

    always_comb begin
        o_sel = FWD_RF;
        if (w_hit_m) begin
            o_sel = FWD_M;
        end else if (w_hit_w) begin
            o_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use bubble, redirect flush and data-memory wait.
// Define HAZARD_PERF_CNT_EN to add the stall/load-use/flush performance counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_regD,
    input  logic [4:0] rs2_regD,
    input  logic [4:0] rs1_regE,
    input  logic [4:0] rs2_regE,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    input  logic       dmem_req_M,
    input  logic       dmem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] loaduse_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535 || CNT_W < 1) begin : g_bad_param
        $error("hazard_ctrl: MEM_TIMEOUT must be 1..65535 and CNT_W at least 1");
    end

    memwait_state_t      r_state;
    memwait_state_t      w_state_next;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [WCNT_W-1:0]   w_wait_cnt_next;
    logic                r_timeout_err;

    logic w_req_miss;
    logic w_mem_wait;
    logic w_load_use;
    logic w_redirect;
    logic w_bubble;
    logic w_err_set;

    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_fwd
        logic [4:0] w_rs;
        fwd_sel_t   w_sel;
        assign w_rs = (gi == 0) ? rs1_regE : rs2_regE;
        hazard_fwd_sel u_fwd_sel (
            .i_rs          (w_rs),
            .i_rd_m        (RdM),
            .i_reg_write_m (RegWriteM),
            .i_rd_w        (RdW),
            .i_reg_write_w (RegWriteW),
            .o_sel         (w_sel)
        );
    end

    assign w_fwd_a   = g_fwd[0].w_sel;
    assign w_fwd_b   = g_fwd[1].w_sel;
    assign ForwardAE = w_fwd_a;
    assign ForwardBE = w_fwd_b;

    // The wait is combinational on dmem_ready so stalls drop in the completing cycle.
    assign w_req_miss = dmem_req_M && !dmem_ready;
    assign w_mem_wait = w_req_miss || ((r_state == MEM_WAIT) && !dmem_ready);

    assign w_load_use = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                        ((RdE == rs1_regD) || (RdE == rs2_regD));

    // A redirect squashes the load-use consumer anyway, so it wins over the bubble.
    assign w_redirect = PCSrcE && !w_mem_wait;
    assign w_bubble   = w_load_use && !PCSrcE && !w_mem_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (w_req_miss) begin
                    w_state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    w_state_next = RUN;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    always_comb begin
        StallF = w_mem_wait || w_bubble;
        StallD = w_mem_wait || w_bubble;
        StallE = w_mem_wait;
        StallM = w_mem_wait;
        FlushD = w_redirect;
        FlushE = w_redirect || w_bubble;
    end

    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (w_req_miss) begin
                    w_wait_cnt_next = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    w_wait_cnt_next = '0;
                end else if (r_wait_cnt != WCNT_MAX) begin
                    w_wait_cnt_next = r_wait_cnt + WCNT_W'(1);
                end
            end
            default: w_wait_cnt_next = '0;
        endcase
    end

    // The error latches on the edge that ends the MEM_TIMEOUT-th consecutive wait cycle.
    assign w_err_set = w_mem_wait && (w_wait_cnt_next == WCNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_next;
            if (w_err_set) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign mem_timeout_err = r_timeout_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_loaduse_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_loaduse_cnt  <= '0;
            r_flush_cnt    <= '0;
        end else begin
            if (StallF) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_bubble) begin
                r_loaduse_cnt <= r_loaduse_cnt + CNT_W'(1);
            end
            if (w_redirect) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign loaduse_cnt_o  = r_loaduse_cnt;
    assign flush_cnt_o    = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, multi-cycle sequences and random vs. model.
module tb_hazard_ctrl;

    localparam int unsigned T_OUT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_regD, rs2_regD, rs1_regE, rs2_regE, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, RegWriteW, dmem_req_M, dmem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout_err;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_o, loaduse_cnt_o, flush_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.MEM_TIMEOUT(T_OUT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_regD(rs1_regD), .rs2_regD(rs2_regD),
        .rs1_regE(rs1_regE), .rs2_regE(rs2_regE), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout_err(mem_timeout_err)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles_o(stall_cycles_o), .loaduse_cnt_o(loaduse_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rse;
        logic       pcs;
        logic [4:0] rdm;
        logic       rwm;
        logic [4:0] rdw;
        logic       rww;
        logic [1:0] efa, efb;
        logic       esf, esd, efd, efe;
    } vec_t;

    vec_t vec [14];

    // Reference model state: an abstract "waiting" flag, a count of consecutive wait cycles.
    bit          m_wait;
    int unsigned m_cnt;
    bit          m_err;
    int unsigned m_st, m_lu, m_fl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                             input logic sf, input logic sd, input logic se, input logic sm,
                             input logic fd, input logic fe);
        chk({tag, ".ForwardAE"}, 32'(ForwardAE), 32'(fa));
        chk({tag, ".ForwardBE"}, 32'(ForwardBE), 32'(fb));
        chk({tag, ".StallF"}, 32'(StallF), 32'(sf));
        chk({tag, ".StallD"}, 32'(StallD), 32'(sd));
        chk({tag, ".StallE"}, 32'(StallE), 32'(se));
        chk({tag, ".StallM"}, 32'(StallM), 32'(sm));
        chk({tag, ".FlushD"}, 32'(FlushD), 32'(fd));
        chk({tag, ".FlushE"}, 32'(FlushE), 32'(fe));
    endtask

    task automatic idle();
        rs1_regD = 0; rs2_regD = 0; rs1_regE = 0; rs2_regE = 0; RdE = 0;
        ResultSrcE = 0; PCSrcE = 0; RdM = 0; RegWriteM = 0; RdW = 0; RegWriteW = 0;
        dmem_req_M = 0; dmem_ready = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_wait = 0; m_cnt = 0; m_err = 0; m_st = 0; m_lu = 0; m_fl = 0;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (RegWriteM && RdM == rs) return 2'b10;
        if (RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        vec[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0};
        vec[1]  = '{0, 0, 5, 0, 0, 0, 0, 5, 1, 5, 1,     2, 0, 0, 0, 0, 0};
        vec[2]  = '{0, 0, 5, 0, 0, 0, 0, 0, 1, 5, 0,     0, 0, 0, 0, 0, 0};
        vec[3]  = '{0, 0, 0, 0, 0, 0, 0, 5, 1, 5, 1,     0, 0, 0, 0, 0, 0};
        vec[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,     0, 0, 0, 0, 0, 0};
        vec[5]  = '{0, 0, 0, 9, 0, 0, 0, 9, 0, 9, 1,     0, 1, 0, 0, 0, 0};
        vec[6]  = '{0, 0, 3, 3, 0, 0, 0, 3, 1, 3, 1,     2, 2, 0, 0, 0, 0};
        vec[7]  = '{0, 0, 12, 20, 0, 0, 0, 20, 1, 12, 1, 1, 2, 0, 0, 0, 0};
        vec[8]  = '{0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0,     0, 0, 1, 1, 0, 1};
        vec[9]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0};
        vec[10] = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0};
        vec[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,     0, 0, 0, 0, 1, 1};
        vec[12] = '{7, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0,     0, 0, 0, 0, 1, 1};
        vec[13] = '{7, 0, 0, 0, 7, 3, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0};

        idle();
        rst_n = 1'b0;
        #3;
        check_ctl("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.err", 32'(mem_timeout_err), 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("reset.stall_cycles", stall_cycles_o, 0);
        chk("reset.loaduse_cnt", loaduse_cnt_o, 0);
        chk("reset.flush_cnt", flush_cnt_o, 0);
`endif
        rst_n = 1'b1;
        next_cycle();
        $display("reset checked");

        // Combinational vectors, FSM idle in RUN
        for (int i = 0; i < 14; i++) begin
            rs1_regD = vec[i].rs1d; rs2_regD = vec[i].rs2d;
            rs1_regE = vec[i].rs1e; rs2_regE = vec[i].rs2e; RdE = vec[i].rde;
            ResultSrcE = vec[i].rse; PCSrcE = vec[i].pcs;
            RdM = vec[i].rdm; RegWriteM = vec[i].rwm; RdW = vec[i].rdw; RegWriteW = vec[i].rww;
            @(negedge clk);
            check_ctl($sformatf("vec%0d", i), vec[i].efa, vec[i].efb,
                      vec[i].esf, vec[i].esd, 1'b0, 1'b0, vec[i].efd, vec[i].efe);
            $display("vec %0d: FA=%b FB=%b SF=%b SD=%b FD=%b FE=%b", i, ForwardAE, ForwardBE,
                     StallF, StallD, FlushD, FlushE);
            next_cycle();
        end

        // Load-use bubble lasts one cycle, then the pipeline moves on
        idle();
        ResultSrcE = 2'b01; RdE = 7; rs2_regD = 7;
        @(negedge clk);
        check_ctl("lu.bubble", 0, 0, 1, 1, 0, 0, 0, 1);
        next_cycle();
        idle();
        @(negedge clk);
        check_ctl("lu.after", 0, 0, 0, 0, 0, 0, 0, 0);
        $display("load-use sequence: StallF=%b FlushE=%b", StallF, FlushE);
        next_cycle();

        // Three-cycle memory wait with a redirect held behind it
        idle();
        dmem_req_M = 1; PCSrcE = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_ctl($sformatf("mw.wait%0d", k), 0, 0, 1, 1, 1, 1, 0, 0);
            next_cycle();
        end
        dmem_ready = 1;
        @(negedge clk);
        check_ctl("mw.ready", 0, 0, 0, 0, 0, 0, 1, 1);
        next_cycle();
        idle();
        @(negedge clk);
        check_ctl("mw.idle", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mw.err", 32'(mem_timeout_err), 0);
        $display("memory-wait sequence done");
        next_cycle();

        // Timeout: err latches after the T_OUT-th wait cycle and is sticky
        dmem_req_M = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("to.stall%0d", k), 32'(StallM), 1);
            next_cycle();
            chk($sformatf("to.err%0d", k), 32'(mem_timeout_err), (k >= int'(T_OUT)) ? 1 : 0);
        end
        dmem_ready = 1;
        @(negedge clk);
        chk("to.ready_stall", 32'(StallF), 0);
        next_cycle();
        idle();
        chk("to.sticky", 32'(mem_timeout_err), 1);
        $display("timeout sequence: err=%b", mem_timeout_err);

        // Reset in the middle of a wait returns the FSM to RUN
        dmem_req_M = 1;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        dmem_req_M = 0;
        #1;
        chk("rst.err", 32'(mem_timeout_err), 0);
        chk("rst.stall_in_reset", 32'(StallE), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.stall_after", 32'(StallE), 0);
        $display("mid-wait reset: err=%b StallE=%b", mem_timeout_err, StallE);
        next_cycle();

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        idle();
        ResultSrcE = 2'b01; RdE = 4; rs1_regD = 4;
        next_cycle();
        idle();
        PCSrcE = 1;
        next_cycle();
        next_cycle();
        idle();
        dmem_req_M = 1;
        next_cycle(); next_cycle(); next_cycle();
        dmem_ready = 1;
        next_cycle();
        idle();
        chk("perf.loaduse", loaduse_cnt_o, 1);
        chk("perf.flush", flush_cnt_o, 2);
        chk("perf.stall", stall_cycles_o, 4);
        $display("perf: stall=%0d loaduse=%0d flush=%0d", stall_cycles_o, loaduse_cnt_o, flush_cnt_o);
`endif

        // Random traffic against the reference model
        do_reset();
        idle();
        next_cycle();
        for (int c = 0; c < 800; c++) begin
            logic e_mw, e_lw, e_sf;
            rs1_regD = 5'($urandom_range(0, 3)); rs2_regD = 5'($urandom_range(0, 3));
            rs1_regE = 5'($urandom_range(0, 3)); rs2_regE = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE = ($urandom_range(0, 3) == 0);
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            dmem_req_M = ($urandom_range(0, 2) == 0);
            dmem_ready = ($urandom_range(0, 2) != 0);

            e_mw = (dmem_req_M && !dmem_ready) || (m_wait && !dmem_ready);
            e_lw = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == rs1_regD || RdE == rs2_regD);
            e_sf = e_mw || (e_lw && !PCSrcE);
            @(negedge clk);
            check_ctl($sformatf("rnd%0d", c), ref_fwd(rs1_regE), ref_fwd(rs2_regE),
                      e_sf, e_sf, e_mw, e_mw, !e_mw && PCSrcE, !e_mw && (PCSrcE || e_lw));
            chk($sformatf("rnd%0d.err", c), 32'(mem_timeout_err), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
            chk($sformatf("rnd%0d.stall_cnt", c), stall_cycles_o, m_st);
            chk($sformatf("rnd%0d.lu_cnt", c), loaduse_cnt_o, m_lu);
            chk($sformatf("rnd%0d.fl_cnt", c), flush_cnt_o, m_fl);
`endif
            $display("rnd %0d: req=%b rdy=%b pc=%b Stall=%b%b%b%b Flush=%b%b err=%b", c, dmem_req_M,
                     dmem_ready, PCSrcE, StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout_err);

            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                e_mw = dmem_req_M && !dmem_ready;
                e_sf = e_mw || (e_lw && !PCSrcE);
            end
            if (e_mw) begin
                m_cnt  = (m_cnt + 1 > T_OUT) ? T_OUT : m_cnt + 1;
                m_wait = 1;
                if (m_cnt == T_OUT) m_err = 1;
            end else begin
                m_wait = 0;
                m_cnt  = 0;
            end
            if (e_sf) m_st++;
            if (e_lw && !PCSrcE && !e_mw) m_lu++;
            if (PCSrcE && !e_mw) m_fl++;
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
